// File: rtl/mandelbrot_engine.sv
// Escape-time Mandelbrot pixel engine: walks a frame in raster order and streams one
// iteration count per pixel over a valid/ready handshake.
module mandelbrot_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24,
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int ITER_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [X_W-1:0]    x_size,
  input  logic [Y_W-1:0]    y_size,
  input  logic [DATA_W-1:0] re_min,
  input  logic [DATA_W-1:0] im_max,
  input  logic [DATA_W-1:0] delta_re,
  input  logic [DATA_W-1:0] delta_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ITER_W-1:0] pix_iter,
  output logic              pix_last
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int MAG_W  = DATA_W + 2;
  localparam logic signed [MAG_W-1:0] Four = MAG_W'(4) <<< FRAC_W;

  typedef enum logic [1:0] {StIdle, StIter, StEmit, StFinish} state_t;

  state_t state_q, state_d;

  logic [X_W-1:0]    xs_q, xs_d, x_q, x_d;
  logic [Y_W-1:0]    ys_q, ys_d, y_q, y_d;
  logic [ITER_W-1:0] max_iter_q, max_iter_d, n_q, n_d, iter_q, iter_d;
  logic [DATA_W-1:0] re_min_q, re_min_d, delta_re_q, delta_re_d, delta_im_q, delta_im_d;
  logic signed [DATA_W-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
  logic signed [DATA_W-1:0] zr_q, zr_d, zi_q, zi_d;

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri;
  logic signed [MAG_W-1:0]  zr2, zi2, mag;
  logic signed [DATA_W-1:0] zri2;
  logic                     at_last;

  // Full-width products; squares keep two guard bits so the magnitude test cannot wrap.
  assign p_rr = PROD_W'(zr_q) * PROD_W'(zr_q);
  assign p_ii = PROD_W'(zi_q) * PROD_W'(zi_q);
  assign p_ri = PROD_W'(zr_q) * PROD_W'(zi_q);
  assign zr2  = MAG_W'(p_rr >>> FRAC_W);
  assign zi2  = MAG_W'(p_ii >>> FRAC_W);
  assign zri2 = DATA_W'(p_ri >>> (FRAC_W - 1));
  assign mag  = zr2 + zi2;

  assign at_last = (x_q == xs_q - X_W'(1)) && (y_q == ys_q - Y_W'(1));

  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    ys_d       = ys_q;
    max_iter_d = max_iter_q;
    re_min_d   = re_min_q;
    delta_re_d = delta_re_q;
    delta_im_d = delta_im_q;
    x_d        = x_q;
    y_d        = y_q;
    n_d        = n_q;
    iter_d     = iter_q;
    c_re_d     = c_re_q;
    c_im_d     = c_im_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xs_d       = x_size;
          ys_d       = y_size;
          max_iter_d = max_iter;
          re_min_d   = re_min;
          delta_re_d = delta_re;
          delta_im_d = delta_im;
          x_d        = '0;
          y_d        = '0;
          n_d        = '0;
          c_re_d     = re_min;
          c_im_d     = im_max;
          zr_d       = '0;
          zi_d       = '0;
          state_d    = (x_size == '0 || y_size == '0) ? StFinish : StIter;
        end
      end
      StIter: begin
        if (abort) begin
          state_d = StIdle;
        end else if (mag > Four || n_q == max_iter_q) begin
          iter_d  = n_q;
          state_d = StEmit;
        end else begin
          zr_d = DATA_W'(zr2 - zi2 + MAG_W'(c_re_q));
          zi_d = zri2 + c_im_q;
          n_d  = n_q + ITER_W'(1);
        end
      end
      StEmit: begin
        if (abort) begin
          state_d = StIdle;
        end else if (pix_ready) begin
          if (at_last) begin
            state_d = StFinish;
          end else begin
            if (x_q == xs_q - X_W'(1)) begin
              x_d    = '0;
              y_d    = y_q + Y_W'(1);
              c_re_d = re_min_q;
              c_im_d = c_im_q - delta_im_q;
            end else begin
              x_d    = x_q + X_W'(1);
              c_re_d = c_re_q + delta_re_q;
            end
            zr_d    = '0;
            zi_d    = '0;
            n_d     = '0;
            state_d = StIter;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      xs_q       <= '0;
      ys_q       <= '0;
      max_iter_q <= '0;
      re_min_q   <= '0;
      delta_re_q <= '0;
      delta_im_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      n_q        <= '0;
      iter_q     <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
    end else begin
      state_q    <= state_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      max_iter_q <= max_iter_d;
      re_min_q   <= re_min_d;
      delta_re_q <= delta_re_d;
      delta_im_q <= delta_im_d;
      x_q        <= x_d;
      y_q        <= y_d;
      n_q        <= n_d;
      iter_q     <= iter_d;
      c_re_q     <= c_re_d;
      c_im_q     <= c_im_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
    end
  end

  // Pixel fields are forced to zero outside EMIT so idle outputs read as all-zero.
  always_comb begin
    busy      = (state_q == StIter) || (state_q == StEmit);
    done      = (state_q == StFinish) && !abort;
    pix_valid = (state_q == StEmit);
    pix_x     = pix_valid ? x_q : '0;
    pix_y     = pix_valid ? y_q : '0;
    pix_iter  = pix_valid ? iter_q : '0;
    pix_last  = pix_valid && at_last;
  end

endmodule
